uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer between uart_receive and ctrl in the UART user project.

---
 rtl/uart_rx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO with first-word-fall-through head, sticky overflow,
// character timeout and a combined interrupt for the UART user project.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   clk_div,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_done,
    input  logic          i_frame_err,
    input  logic          i_rd_en,
    input  logic          i_flush,
    input  logic          i_ovf_clr,
    input  logic          i_irq_en,
    input  logic [AW:0]   i_thresh,
    output logic [7:0]    o_rd_data,
    output logic          o_rd_ferr,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_level,
    output logic          o_overflow,
    output logic          o_timeout,
    output logic          o_irq
);

    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];
    localparam logic [5:0]  TO_MAX   = TIMEOUT_BITS[5:0];

    logic [8:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          overflow_r;
    logic          timeout_r;
    logic [31:0]   bit_cyc_r;
    logic [5:0]    bit_cnt_r;

    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          ovf_set_s;
    logic [8:0]    head_s;
    logic [31:0]   div_last_s;
    logic [31:0]   bit_cyc_nxt_s;
    logic [5:0]    bit_cnt_nxt_s;

    assign empty_s    = (level_r == '0);
    assign full_s     = (level_r == LVL_FULL);
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop_s      = i_rd_en & ~empty_s & ~i_flush;
    assign push_s     = i_rx_done & (~full_s | pop_s) & ~i_flush;
    assign ovf_set_s  = i_rx_done & full_s & ~pop_s & ~i_flush;
    assign head_s     = mem_r[rd_ptr_r];
    assign div_last_s = (clk_div > 32'd1) ? (clk_div - 32'd1) : 32'd0;

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {i_frame_err, i_rx_data};
        end
    end

    // Pointers and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (i_flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (push_s && !pop_s)      level_r <= level_r + {{AW{1'b0}}, 1'b1};
            else if (pop_s && !push_s) level_r <= level_r - {{AW{1'b0}}, 1'b1};
        end
    end

    // Sticky overflow; a new drop beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          overflow_r <= 1'b0;
        else if (ovf_set_s)  overflow_r <= 1'b1;
        else if (i_ovf_clr)  overflow_r <= 1'b0;
    end

    // Idle bit-time counting toward the character timeout.
    always_comb begin
        bit_cyc_nxt_s = bit_cyc_r;
        bit_cnt_nxt_s = bit_cnt_r;
        if (empty_s || push_s || pop_s || i_flush) begin
            bit_cyc_nxt_s = 32'd0;
            bit_cnt_nxt_s = 6'd0;
        end else if (bit_cyc_r >= div_last_s) begin
            bit_cyc_nxt_s = 32'd0;
            if (bit_cnt_r != TO_MAX) bit_cnt_nxt_s = bit_cnt_r + 6'd1;
            else                     bit_cnt_nxt_s = bit_cnt_r;
        end else begin
            bit_cyc_nxt_s = bit_cyc_r + 32'd1;
        end
    end

    // Timeout counters and registered timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cyc_r <= 32'd0;
            bit_cnt_r <= 6'd0;
            timeout_r <= 1'b0;
        end else begin
            bit_cyc_r <= bit_cyc_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            timeout_r <= (bit_cnt_nxt_s == TO_MAX);
        end
    end

    // Head presentation forces zeros when empty so stale memory never leaks out.
    always_comb begin
        if (empty_s) begin
            o_rd_data = 8'h00;
            o_rd_ferr = 1'b0;
        end else begin
            o_rd_data = head_s[7:0];
            o_rd_ferr = head_s[8];
        end
    end

    assign o_empty    = empty_s;
    assign o_full     = full_s;
    assign o_level    = level_r;
    assign o_overflow = overflow_r;
    assign o_timeout  = timeout_r;
    assign o_irq      = i_irq_en & (((i_thresh != '0) && (level_r >= i_thresh))
                                    | timeout_r | overflow_r);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] clk_div;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_frame_err;
    logic        i_rd_en;
    logic        i_flush;
    logic        i_ovf_clr;
    logic        i_irq_en;
    logic [4:0]  i_thresh;
    logic [7:0]  o_rd_data;
    logic        o_rd_ferr;
    logic        o_empty;
    logic        o_full;
    logic [4:0]  o_level;
    logic        o_overflow;
    logic        o_timeout;
    logic        o_irq;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_frame_err(i_frame_err),
        .i_rd_en(i_rd_en), .i_flush(i_flush), .i_ovf_clr(i_ovf_clr),
        .i_irq_en(i_irq_en), .i_thresh(i_thresh),
        .o_rd_data(o_rd_data), .o_rd_ferr(o_rd_ferr), .o_empty(o_empty),
        .o_full(o_full), .o_level(o_level), .o_overflow(o_overflow),
        .o_timeout(o_timeout), .o_irq(o_irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic ferr);
        i_rx_data   = b;
        i_frame_err = ferr;
        i_rx_done   = 1'b1;
        tick();
        i_rx_done   = 1'b0;
        i_frame_err = 1'b0;
    endtask

    task automatic pop_byte;
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] exp_b;
        rst_n = 1'b0; clk_div = 32'd4; i_rx_data = 8'h00; i_rx_done = 1'b0;
        i_frame_err = 1'b0; i_rd_en = 1'b0; i_flush = 1'b0; i_ovf_clr = 1'b0;
        i_irq_en = 1'b0; i_thresh = 5'd0;
        tick(); tick();
        check_eq("rst_empty",   32'(o_empty),    32'd1);
        check_eq("rst_level",   32'(o_level),    32'd0);
        check_eq("rst_irq",     32'(o_irq),      32'd0);
        check_eq("rst_data",    32'(o_rd_data),  32'h00);
        check_eq("rst_full",    32'(o_full),     32'd0);
        check_eq("rst_ovf",     32'(o_overflow), 32'd0);
        check_eq("rst_timeout", 32'(o_timeout),  32'd0);
        check_eq("rst_ferr",    32'(o_rd_ferr),  32'd0);
        rst_n = 1'b1;
        tick();

        // Basic ordering and FWFT head
        push_byte(8'h41, 1'b0);
        check_eq("fwft_first", 32'(o_rd_data), 32'h41);
        push_byte(8'h42, 1'b0);
        push_byte(8'h43, 1'b0);
        check_eq("lvl3", 32'(o_level), 32'd3);
        check_eq("head41", 32'(o_rd_data), 32'h41);
        for (int i = 0; i < 3; i++) begin
            exp_b = 8'h41 + 8'(i);
            check_eq($sformatf("order%0d", i), 32'(o_rd_data), 32'(exp_b));
            pop_byte();
        end
        check_eq("drained_empty", 32'(o_empty), 32'd1);
        check_eq("drained_data",  32'(o_rd_data), 32'h00);

        // Fill, overflow, full push+pop, overflow clear
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b0);
        check_eq("full", 32'(o_full), 32'd1);
        check_eq("full_ovf0", 32'(o_overflow), 32'd0);
        push_byte(8'h99, 1'b0);
        check_eq("ovf_set", 32'(o_overflow), 32'd1);
        check_eq("ovf_lvl", 32'(o_level), 32'd16);
        check_eq("ovf_head", 32'(o_rd_data), 32'h10);
        i_irq_en = 1'b1;
        #1;
        check_eq("irq_ovf", 32'(o_irq), 32'd1);
        i_rd_en = 1'b1; i_rx_data = 8'hA5; i_rx_done = 1'b1;
        tick();
        i_rd_en = 1'b0; i_rx_done = 1'b0;
        check_eq("pp_full_lvl",  32'(o_level), 32'd16);
        check_eq("pp_full_head", 32'(o_rd_data), 32'h11);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        check_eq("ovf_clr", 32'(o_overflow), 32'd0);
        check_eq("irq_after_clr", 32'(o_irq), 32'd0);
        i_irq_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? (8'h11 + 8'(i)) : 8'hA5;
            check_eq($sformatf("drain%0d", i), 32'(o_rd_data), 32'(exp_b));
            pop_byte();
        end
        check_eq("drain_empty", 32'(o_empty), 32'd1);

        // Threshold interrupt
        i_thresh = 5'd4; i_irq_en = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i), 1'b0);
        check_eq("thr_below", 32'(o_irq), 32'd0);
        push_byte(8'h63, 1'b0);
        check_eq("thr_hit", 32'(o_irq), 32'd1);
        pop_byte();
        check_eq("thr_pop", 32'(o_irq), 32'd0);

        // Flush beats a simultaneous arrival
        i_flush = 1'b1; i_rx_data = 8'h77; i_rx_done = 1'b1;
        tick();
        i_flush = 1'b0; i_rx_done = 1'b0;
        check_eq("flush_lvl",   32'(o_level), 32'd0);
        check_eq("flush_empty", 32'(o_empty), 32'd1);
        i_thresh = 5'd0;

        // Character timeout: clk_div=4 -> 40 bits * 4 = 160 cycles
        push_byte(8'h55, 1'b0);
        n = 0;
        while (!o_timeout && n < 300) begin
            tick();
            n++;
        end
        check_eq("timeout_cycles", 32'(n), 32'd160);
        check_eq("timeout_irq", 32'(o_irq), 32'd1);
        pop_byte();
        check_eq("timeout_drop", 32'(o_timeout), 32'd0);
        check_eq("timeout_empty", 32'(o_empty), 32'd1);
        i_irq_en = 1'b0;

        // Frame error travels with its byte
        push_byte(8'h5A, 1'b1);
        check_eq("ferr_head", 32'(o_rd_ferr), 32'd1);
        check_eq("ferr_data", 32'(o_rd_data), 32'h5A);
        pop_byte();
        check_eq("ferr_gone", 32'(o_rd_ferr), 32'd0);

        // Push and pop while empty: pop ignored
        i_rd_en = 1'b1; i_rx_data = 8'h3C; i_rx_done = 1'b1;
        tick();
        i_rd_en = 1'b0; i_rx_done = 1'b0;
        check_eq("pp_empty_lvl",  32'(o_level), 32'd1);
        check_eq("pp_empty_data", 32'(o_rd_data), 32'h3C);

        // Asynchronous reset mid-operation
        push_byte(8'h3D, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_lvl",   32'(o_level), 32'd0);
        check_eq("async_rst_empty", 32'(o_empty), 32'd1);
        check_eq("async_rst_data",  32'(o_rd_data), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
